// File: rtl/mem_pkg.sv
// mem_pkg: shared definitions for the data-memory responder.
//   - default datapath widths (must match the control unit's datapath)
//   - FSM state constants (IDLE, WAIT, RESP)
//   - request-op encoding and a strobe decoder
package mem_pkg;

  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 32;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  // Encoding is {mem_write, mem_read}, so both strobes high lands on OP_BAD.
  typedef enum logic [1:0] {
    OP_NONE  = 2'b00,
    OP_LOAD  = 2'b01,
    OP_STORE = 2'b10,
    OP_BAD   = 2'b11
  } op_e;

  function automatic op_e decode_op(input logic rd, input logic wr);
    return op_e'({wr, rd});
  endfunction

endpackage

// File: rtl/mem_array.sv
// mem_array: single-port synchronous RAM, DEPTH x DATA_W, no reset.
// Ports:
//   clk   - rising-edge clock
//   we    - write enable; wdata is written to addr
//   re    - read enable; rdata register loads mem[addr]
//   addr  - word address (caller guarantees addr < DEPTH when we/re are set)
//   wdata - write data
//   rdata - registered read data; holds until the next enabled read
module mem_array #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Storage write and registered read port.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[addr] <= wdata;
    end
    if (re) begin
      rdata_q <= mem_q[addr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: memory-side responder for load/store strobes.
// Accepts one request at a time, waits a fixed latency LAT, then returns a
// one-cycle ack (with err for malformed requests, rdata for loads).
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   mem_read, mem_write - request strobes, sampled while ready=1
//   addr, wdata         - request address/store data, captured at accept
//   ready               - a new request can be accepted this cycle
//   ack                 - one-cycle completion pulse
//   rdata               - load data (0 after an error response)
//   err                 - qualifies ack: request was rejected
module data_mem_responder
  import mem_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = 256,
  parameter int LAT    = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              ready,
  output logic              ack,
  output logic [DATA_W-1:0] rdata,
  output logic              err
);

  // With LAT=1 the accept edge is also the commit edge, so WAIT is skipped.
  localparam bit         SINGLE   = (LAT == 1);
  localparam logic [3:0] CNT_LOAD = (LAT > 1) ? 4'(LAT - 2) : 4'd0;

  logic [1:0]        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  op_e               op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              ready_q, ready_d;
  logic              ack_q, ack_d;
  logic              err_q, err_d;
  logic              zero_q, zero_d;

  logic              accept_s;
  logic              commit_s;
  logic              bad_addr_s;
  logic              ram_we_s;
  logic              ram_re_s;
  op_e               cmt_op_s;
  logic [ADDR_W-1:0] cmt_addr_s;
  logic [DATA_W-1:0] cmt_wdata_s;
  logic [DATA_W-1:0] ram_rdata_s;

  assign accept_s = ready_q & (mem_read | mem_write);

  // FSM next state, request capture and commit-edge selection.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    commit_s    = 1'b0;
    cmt_op_s    = op_q;
    cmt_addr_s  = addr_q;
    cmt_wdata_s = wdata_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          op_d    = decode_op(mem_read, mem_write);
          addr_d  = addr;
          wdata_d = wdata;
          cnt_d   = CNT_LOAD;
          if (SINGLE) begin
            // Commit straight from the live inputs on the accept edge.
            state_d     = ST_RESP;
            commit_s    = 1'b1;
            cmt_op_s    = op_d;
            cmt_addr_s  = addr;
            cmt_wdata_s = wdata;
          end else begin
            state_d = ST_WAIT;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d  = ST_RESP;
          commit_s = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign bad_addr_s = (32'(cmt_addr_s) >= 32'(DEPTH));

  // Response flags and array strobes; rst suppresses any commit.
  always_comb begin
    ack_d    = commit_s & ~rst;
    err_d    = 1'b0;
    ram_we_s = 1'b0;
    ram_re_s = 1'b0;
    zero_d   = zero_q;
    if (ack_d) begin
      err_d    = (cmt_op_s == OP_BAD) | bad_addr_s;
      ram_we_s = (cmt_op_s == OP_STORE) & ~bad_addr_s;
      ram_re_s = (cmt_op_s == OP_LOAD) & ~bad_addr_s;
      if (err_d) begin
        zero_d = 1'b1;
      end else if (ram_re_s) begin
        zero_d = 1'b0;
      end else begin
        zero_d = zero_q;
      end
    end else begin
      err_d = 1'b0;
    end
    ready_d = (state_d == ST_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      op_q    <= OP_NONE;
      addr_q  <= {ADDR_W{1'b0}};
      wdata_q <= {DATA_W{1'b0}};
      ready_q <= 1'b1;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      zero_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      ready_q <= ready_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      zero_q  <= zero_d;
    end
  end

  mem_array #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .DEPTH (DEPTH)
  ) u_mem_array (
    .clk  (clk),
    .we   (ram_we_s),
    .re   (ram_re_s),
    .addr (cmt_addr_s),
    .wdata(cmt_wdata_s),
    .rdata(ram_rdata_s)
  );

  // The RAM read register is not reset; zero_q masks it after reset/errors.
  assign rdata = zero_q ? {DATA_W{1'b0}} : ram_rdata_s;
  assign ready = ready_q;
  assign ack   = ack_q;
  assign err   = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: three instances (LAT=2/DEPTH=200, LAT=1,
// LAT=3) driven by a vector table plus hand-written multi-cycle sequences.
module tb_data_mem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_s  [3];
  logic        rd_s   [3];
  logic        wr_s   [3];
  logic [7:0]  ad_s   [3];
  logic [31:0] wd_s   [3];
  logic        rdy_s  [3];
  logic        ack_s  [3];
  logic        err_s  [3];
  logic [31:0] rdat_s [3];

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    int          inst;
    logic        rd;
    logic        wr;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic        exp_err;
    logic [31:0] exp_rdata;
    logic        chk_rdata;
    string       name;
  } vec_t;

  vec_t vecs[$];

  data_mem_responder #(.ADDR_W(8), .DATA_W(32), .DEPTH(200), .LAT(2)) u_lat2 (
    .clk(clk), .rst(rst_s[0]), .mem_read(rd_s[0]), .mem_write(wr_s[0]),
    .addr(ad_s[0]), .wdata(wd_s[0]), .ready(rdy_s[0]), .ack(ack_s[0]),
    .rdata(rdat_s[0]), .err(err_s[0]));

  data_mem_responder #(.ADDR_W(8), .DATA_W(32), .DEPTH(256), .LAT(1)) u_lat1 (
    .clk(clk), .rst(rst_s[1]), .mem_read(rd_s[1]), .mem_write(wr_s[1]),
    .addr(ad_s[1]), .wdata(wd_s[1]), .ready(rdy_s[1]), .ack(ack_s[1]),
    .rdata(rdat_s[1]), .err(err_s[1]));

  data_mem_responder #(.ADDR_W(8), .DATA_W(32), .DEPTH(256), .LAT(3)) u_lat3 (
    .clk(clk), .rst(rst_s[2]), .mem_read(rd_s[2]), .mem_write(wr_s[2]),
    .addr(ad_s[2]), .wdata(wd_s[2]), .ready(rdy_s[2]), .ack(ack_s[2]),
    .rdata(rdat_s[2]), .err(err_s[2]));

  function automatic int lat_of(input int i);
    case (i)
      0:       return 2;
      1:       return 1;
      default: return 3;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void add(input int inst, input logic rd, input logic wr,
                              input logic [7:0] a, input logic [31:0] d,
                              input logic ee, input logic [31:0] er,
                              input logic cr, input string nm);
    vec_t v;
    v.inst = inst; v.rd = rd; v.wr = wr; v.addr = a; v.wdata = d;
    v.exp_err = ee; v.exp_rdata = er; v.chk_rdata = cr; v.name = nm;
    vecs.push_back(v);
  endfunction

  // Issue one request (strobe for one cycle) and report the ack cycle.
  task automatic req(input int i, input logic rd, input logic wr,
                     input logic [7:0] a, input logic [31:0] d,
                     output int lat, output logic e, output logic [31:0] rv);
    int guard = 0;
    while (!rdy_s[i] && guard < 20) begin
      tick();
      guard++;
    end
    if (guard >= 20) check("ready_timeout", 32'd0, 32'd1);
    rd_s[i] = rd; wr_s[i] = wr; ad_s[i] = a; wd_s[i] = d;
    tick();
    rd_s[i] = 1'b0; wr_s[i] = 1'b0;
    lat = 1;
    while (!ack_s[i] && lat < 20) begin
      tick();
      lat++;
    end
    e  = err_s[i];
    rv = rdat_s[i];
    tick();
  endtask

  // Strobes must be known whenever a responder is ready.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rdy_s[i] === 1'b1 && rst_s[i] === 1'b0)
        check("strobe_known", {31'd0, $isunknown({rd_s[i], wr_s[i]})}, 32'd0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat;
    logic        e;
    logic [31:0] rv;
    int          acks;

    // inst, rd, wr, addr, wdata, exp_err, exp_rdata, chk_rdata, name
    add(0, 1'b0, 1'b1, 8'h05, 32'hDEADBEEF, 1'b0, 32'h0,        1'b0, "st05");
    add(0, 1'b1, 1'b0, 8'h05, 32'h0,        1'b0, 32'hDEADBEEF, 1'b1, "ld05");
    add(0, 1'b0, 1'b1, 8'h01, 32'h12345678, 1'b0, 32'h0,        1'b0, "st01");
    add(0, 1'b1, 1'b1, 8'h01, 32'h55555555, 1'b1, 32'h0,        1'b1, "both01");
    add(0, 1'b1, 1'b0, 8'h01, 32'h0,        1'b0, 32'h12345678, 1'b1, "ld01");
    add(0, 1'b0, 1'b1, 8'hC8, 32'h99999999, 1'b1, 32'h0,        1'b1, "stC8");
    add(0, 1'b0, 1'b1, 8'hC7, 32'hCAFEF00D, 1'b0, 32'h0,        1'b1, "stC7");
    add(0, 1'b1, 1'b0, 8'hC7, 32'h0,        1'b0, 32'hCAFEF00D, 1'b1, "ldC7");
    add(0, 1'b1, 1'b0, 8'hC8, 32'h0,        1'b1, 32'h0,        1'b1, "ldC8");
    add(0, 1'b1, 1'b0, 8'hC7, 32'h0,        1'b0, 32'hCAFEF00D, 1'b1, "ldC7b");
    add(1, 1'b0, 1'b1, 8'h00, 32'h0000000A, 1'b0, 32'h0,        1'b0, "l1st00");
    add(1, 1'b0, 1'b1, 8'h01, 32'h0000000B, 1'b0, 32'h0,        1'b0, "l1st01");
    add(1, 1'b1, 1'b0, 8'h00, 32'h0,        1'b0, 32'h0000000A, 1'b1, "l1ld00");
    add(1, 1'b1, 1'b0, 8'h01, 32'h0,        1'b0, 32'h0000000B, 1'b1, "l1ld01");
    add(1, 1'b1, 1'b0, 8'h00, 32'h0,        1'b0, 32'h0000000A, 1'b1, "l1ld00b");
    add(2, 1'b0, 1'b1, 8'h10, 32'h00000000, 1'b0, 32'h0,        1'b0, "l3st10");

    for (int i = 0; i < 3; i++) begin
      rst_s[i] = 1'b1; rd_s[i] = 1'b0; wr_s[i] = 1'b0;
      ad_s[i] = 8'h00; wd_s[i] = 32'h0;
    end
    tick();
    tick();
    for (int i = 0; i < 3; i++) rst_s[i] = 1'b0;

    for (int i = 0; i < 3; i++) begin
      check("rst_ready", {31'd0, rdy_s[i]}, 32'd1);
      check("rst_ack",   {31'd0, ack_s[i]}, 32'd0);
      check("rst_err",   {31'd0, err_s[i]}, 32'd0);
      check("rst_rdata", rdat_s[i],         32'd0);
    end

    foreach (vecs[k]) begin
      req(vecs[k].inst, vecs[k].rd, vecs[k].wr, vecs[k].addr, vecs[k].wdata, lat, e, rv);
      check({vecs[k].name, "_lat"}, 32'(lat), 32'(lat_of(vecs[k].inst)));
      check({vecs[k].name, "_err"}, {31'd0, e}, {31'd0, vecs[k].exp_err});
      if (vecs[k].chk_rdata) check({vecs[k].name, "_rdata"}, rv, vecs[k].exp_rdata);
    end

    // rdata holds the last load value between acks.
    for (int c = 0; c < 3; c++) begin
      check("hold_rdata", rdat_s[1], 32'h0000000A);
      check("hold_ack", {31'd0, ack_s[1]}, 32'd0);
      tick();
    end

    // Strobe held continuously with LAT=1: one accept every two cycles.
    rd_s[1] = 1'b1; ad_s[1] = 8'h01;
    acks = 0;
    for (int c = 0; c < 8; c++) begin
      check("cont_ready", {31'd0, rdy_s[1]}, (c % 2 == 0) ? 32'd1 : 32'd0);
      check("cont_ack",   {31'd0, ack_s[1]}, (c % 2 == 1) ? 32'd1 : 32'd0);
      if (c % 2 == 1) check("cont_rdata", rdat_s[1], 32'h0000000B);
      if (ack_s[1]) acks++;
      tick();
    end
    rd_s[1] = 1'b0;
    check("cont_acks", 32'(acks), 32'd4);

    // Store aborted by rst in cycle 1 (LAT=3): no ack, data never committed.
    wr_s[2] = 1'b1; ad_s[2] = 8'h10; wd_s[2] = 32'h11111111;
    tick();
    wr_s[2] = 1'b0; rst_s[2] = 1'b1;
    check("abort_ready_c1", {31'd0, rdy_s[2]}, 32'd0);
    tick();
    rst_s[2] = 1'b0;
    check("abort_ready_c2", {31'd0, rdy_s[2]}, 32'd1);
    for (int c = 0; c < 4; c++) begin
      check("abort_no_ack", {31'd0, ack_s[2]}, 32'd0);
      tick();
    end
    req(2, 1'b1, 1'b0, 8'h10, 32'h0, lat, e, rv);
    check("abort_ld_lat", 32'(lat), 32'd3);
    check("abort_ld_err", {31'd0, e}, 32'd0);
    check("abort_ld_rdata", rv, 32'h00000000);

    // rst together with an accept: request is not captured.
    rst_s[0] = 1'b1; wr_s[0] = 1'b1; ad_s[0] = 8'h05; wd_s[0] = 32'hBAD0BAD0;
    tick();
    rst_s[0] = 1'b0; wr_s[0] = 1'b0;
    for (int c = 0; c < 4; c++) begin
      check("rstacc_ready", {31'd0, rdy_s[0]}, 32'd1);
      check("rstacc_ack",   {31'd0, ack_s[0]}, 32'd0);
      tick();
    end
    req(0, 1'b1, 1'b0, 8'h05, 32'h0, lat, e, rv);
    check("rstacc_ld_err", {31'd0, e}, 32'd0);
    check("rstacc_ld_rdata", rv, 32'hDEADBEEF);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
